// File: rtl/sram_access_arbiter.sv
// Arbitrates one SRAM_SAVE port between a posted write stream and a read requester.
// Reads win in IDLE unless a pending write has been passed over STARVE_MAX times.
module sram_access_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iWrValid,
  output logic                          oWrReady,
  input  logic [ADDR_W-1:0]             iWrAddr,
  input  logic [DATA_W-1:0]             iWrData,
  input  logic                          iRdReq,
  input  logic [ADDR_W-1:0]             iRdAddr,
  output logic                          oRdAck,
  output logic                          oRdValid,
  output logic [DATA_W-1:0]             oRdData,
  output logic                          oControlState,
  output logic [ADDR_W-1:0]             oMemoryAddress,
  output logic [DATA_W-1:0]             oMemoryData,
  input  logic [DATA_W-1:0]             iMemoryData,
  output logic                          oBusy,
  output logic [$clog2(FIFO_DEPTH):0]   oWrPending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int LW = $clog2(READ_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SET, S_WR_HOLD, S_WR_TURN, S_RD_ADDR, S_RD_WAIT
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [SW-1:0]       r_starve;
  logic [LW-1:0]       r_wait;
  logic                r_ctrl;
  logic                r_ack;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_maddr;
  logic [DATA_W-1:0]   r_mdata;
  logic [DATA_W-1:0]   r_rddata;

  logic w_push;
  logic w_pop;
  logic w_empty;
  logic w_wr_win;

  assign oWrReady = ~iRST & (r_count < CW'(FIFO_DEPTH));
  assign w_push   = iWrValid & oWrReady;
  assign w_pop    = (r_state == S_WR_SET);
  assign w_empty  = (r_count == '0);
  assign w_wr_win = ~w_empty & (~iRdReq | (r_starve == SW'(STARVE_MAX)));

  always_ff @(posedge iCLK) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= iWrAddr;
      r_fifo_data[r_wptr] <= iWrData;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state  <= S_IDLE;
      r_starve <= '0;
      r_wait   <= '0;
      r_ctrl   <= 1'b0;
      r_ack    <= 1'b0;
      r_valid  <= 1'b0;
      r_maddr  <= '0;
      r_mdata  <= '0;
      r_rddata <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_ctrl  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_wr_win) begin
            r_state  <= S_WR_SET;
            r_ctrl   <= 1'b1;
            r_maddr  <= r_fifo_addr[r_rptr];
            r_mdata  <= r_fifo_data[r_rptr];
            r_starve <= '0;
          end else if (iRdReq) begin
            r_state <= S_RD_ADDR;
            r_ack   <= 1'b1;
            r_maddr <= iRdAddr;
            if (!w_empty && r_starve != SW'(STARVE_MAX))
              r_starve <= r_starve + SW'(1);
          end
        end
        S_WR_SET:  r_state <= S_WR_HOLD;
        S_WR_HOLD: r_state <= S_WR_TURN;
        S_WR_TURN: r_state <= S_IDLE;
        S_RD_ADDR: begin
          r_wait  <= LW'(READ_LAT - 2);
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // last wait cycle: SRAM data is on the bus now
          if (r_wait == '0) begin
            r_rddata <= iMemoryData;
            r_valid  <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wait <= r_wait - LW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_empty) r_starve <= '0;
    end
  end

  assign oRdAck         = r_ack;
  assign oRdValid       = r_valid;
  assign oRdData        = r_rddata;
  assign oControlState  = r_ctrl;
  assign oMemoryAddress = r_maddr;
  assign oMemoryData    = r_mdata;
  assign oBusy          = (r_state != S_IDLE);
  assign oWrPending     = r_count;

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the single SRAM port between two requesters: a camera-side write stream and a display/processing-side read requester.
- Drives the SRAM_SAVE control interface: iControlState, iMemoryAddress, iMemoryData, oMemoryData.
- Buffers posted writes in a small FIFO and arbitrates with read priority plus a write starvation guard.
- Sequences the write/turnaround/read cycles so the one-cycle registered WE and data-capture lag of SRAM_SAVE is always respected.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.
- FIFO_DEPTH, 4, write posting FIFO entries; power of 2, at least 2.
- READ_LAT, 2, cycles from read address launch to data valid on iMemoryData; at least 2.
- STARVE_MAX, 8, maximum consecutive read grants while a write is pending.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset: synchronous, active-high.
- iWrValid  in  1  write request; a beat is accepted when iWrValid && oWrReady.
- oWrReady  out  1  FIFO not full.
- iWrAddr  in  ADDR_W  write address.
- iWrData  in  DATA_W  write data.
- iRdReq  in  1  read request; held with iRdAddr until oRdAck.
- iRdAddr  in  ADDR_W  read address.
- oRdAck  out  1  one-cycle pulse: read granted, address latched.
- oRdValid  out  1  one-cycle pulse: oRdData valid.
- oRdData  out  DATA_W  read data.
- oControlState  out  1  to SRAM_SAVE iControlState (1 = write).
- oMemoryAddress  out  ADDR_W  to SRAM_SAVE iMemoryAddress.
- oMemoryData  out  DATA_W  to SRAM_SAVE iMemoryData.
- iMemoryData  in  DATA_W  from SRAM_SAVE oMemoryData.
- oBusy  out  1  state is not IDLE.
- oWrPending  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values:
  - oControlState, oMemoryAddress, oMemoryData, oRdAck, oRdValid, oRdData, oBusy: all 0.
  - oWrPending 0; FIFO pointers and starve counter cleared.
  - oWrReady 0 while iRST is high, 1 on the first cycle after.
- All SRAM-side outputs are registered.
- States: IDLE, WR_SET, WR_HOLD, WR_TURN, RD_ADDR, RD_WAIT.
- Arbitration happens only in IDLE, decided at the clock edge that ends the IDLE cycle:
  - If the FIFO is non-empty and (iRdReq==0 or starve==STARVE_MAX): go to WR_SET.
  - Else if iRdReq==1: go to RD_ADDR, latch iRdAddr, starve += 1 if the FIFO is non-empty.
  - Else stay in IDLE.
- Starve counter: cleared on any write grant and whenever the FIFO is empty; saturates at STARVE_MAX.
- Write sequence, 3 cycles then IDLE:
  - WR_SET: oControlState=1; oMemoryAddress and oMemoryData = FIFO head; FIFO pops at the end of this cycle.
  - WR_HOLD: oControlState=0; address and data held. SRAM_SAVE asserts WE_N low in this cycle.
  - WR_TURN: oControlState=0; address held; SRAM_SAVE bus released. Bus turnaround before any read.
- Read sequence, where A is the RD_ADDR cycle:
  - Cycle A: oRdAck=1, oControlState=0, oMemoryAddress = latched address.
  - RD_WAIT lasts READ_LAT-1 cycles with the address held.
  - iMemoryData is sampled at the end of cycle A+READ_LAT-1.
  - Cycle A+READ_LAT: oRdValid=1, oRdData = sampled value, state IDLE.
- Throughput: one read per READ_LAT+1 cycles; one write per 4 cycles.
- In IDLE: oControlState=0; oMemoryAddress and oMemoryData keep their last values.
- FIFO:
  - Push when iWrValid && oWrReady.
  - oWrReady = occupancy < FIFO_DEPTH, computed from the registered count. A pop in the same cycle does not raise ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Writes are issued strictly in FIFO order.
- iRdReq dropped before ack: the request is ignored. iRdAddr changes after ack have no effect.
- iRST mid-operation: on the next cycle every output and state takes its reset value; the FIFO is flushed; an in-flight read produces no oRdValid.

Test Plan:
- Write, no reads: reset, then write 0x00010/0xBEEF -> WR_SET exactly 1 cycle later with oControlState=1; address 0x00010 held 3 cycles; oMemoryData=0xBEEF; oWrPending goes 1 -> 0.
- Read-after-write (SRAM_SAVE plus async SRAM model): write 0x00010/0xBEEF, then read 0x00010 -> oRdAck in cycle A; oRdValid with 0xBEEF in cycle A+2; at least one WR_TURN cycle between the write and RD_ADDR.
- Simultaneous contention: one write buffered, iRdReq high in the same IDLE cycle, starve=0 -> read granted first; write issued right after that read.
- Starvation: iRdReq held high continuously, one write pending -> exactly 8 reads granted, then WR_SET; starve returns to 0.
- FIFO full and ordering: 5 back-to-back writes while reads hog the port -> oWrReady low after the 4th; 5th accepted after the first pop; SRAM model shows all 5 written in order.
- Reset mid-write: assert iRST during WR_HOLD with 2 entries pending -> next cycle oControlState=0, oWrPending=0, oBusy=0; no further writes; no oRdValid.
